lcd_nibble_reader: RTL

- HD44780-compatible read engine for the 4-bit LCD interface. It is the reading counterpart of the existing 4-bit nibble writer.
- Performs one bus read cycle (RW=1): high nibble, then low nibble, assembled into a byte.
- Optional busy-flag poll mode repeats the read of IR (RS=0) until BF (bit 7) clears or a poll limit is hit.
- Sits between the LCD command sequencer and the pin-level bus mux. The top level tri-states DB7..DB4 whenever rd_active=1.

---
 rtl/lcd_pkg.sv | 32 +++
 rtl/lcd_sync2.sv | 34 +++
 rtl/lcd_nibble_reader.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_pkg
//  Purpose  : Shared HD44780 4-bit bus definitions: read-engine state
//             encoding, default 100 MHz bus timing and register bit positions.
//  Revision : 1.0 - initial release
// ============================================================================
package lcd_pkg;

  // Read-engine state encoding (explicit 3-bit width)
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_EH1   = 3'd2,
    ST_EL1   = 3'd3,
    ST_EH2   = 3'd4,
    ST_EL2   = 3'd5
  } lcd_rd_state_t;

  // Default bus timing in 100 MHz clock cycles
  localparam int C_T_AS      = 6;    // RS/RW setup before E rises (>=40 ns)
  localparam int C_T_PW      = 25;   // E high time per nibble (>=230 ns)
  localparam int C_T_LOW     = 30;   // E low time, completes a >=500 ns E cycle
  localparam int C_MAX_POLLS = 1000; // byte reads before a busy poll gives up
  localparam int C_CW        = 16;   // timing counter width
  localparam int C_PW        = 10;   // poll counter width

  // HD44780 instruction-register bit positions
  localparam int C_BF_BIT    = 7;    // busy flag

endpackage
`default_nettype wire

// File: rtl/lcd_sync2.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_sync2
//  Purpose  : Two-flop synchronizer bringing the asynchronous DB7..DB4 pins
//             into the clk domain.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_sync2 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two back-to-back flops; only the second stage is used downstream
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/lcd_nibble_reader.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_nibble_reader
//  Purpose  : HD44780 4-bit read engine. Runs one RW=1 bus cycle (high nibble
//             then low nibble) and optionally re-reads the instruction
//             register until the busy flag clears or a poll limit is reached.
//  Revision : 1.0 - initial release
// ============================================================================
module lcd_nibble_reader
  import lcd_pkg::*;
#(
  parameter int T_AS      = C_T_AS,
  parameter int T_PW      = C_T_PW,
  parameter int T_LOW     = C_T_LOW,
  parameter int MAX_POLLS = C_MAX_POLLS,
  parameter int CW        = C_CW,
  parameter int PW        = C_PW
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       rd_req,
  input  logic       rd_rs,
  input  logic       rd_poll,
  output logic       rd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       rd_timeout,
  output logic       rd_active,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  input  logic [3:0] db_in
);

  lcd_rd_state_t r_state;
  lcd_rd_state_t w_state_nx;

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_lim;
  logic          w_last;
  logic [PW-1:0] r_poll_cnt;
  logic          r_rs;
  logic          r_poll_en;
  logic [3:0]    r_hi;
  logic [3:0]    r_lo;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_timeout;
  logic [3:0]    w_db;
  logic [7:0]    w_byte;
  logic          w_accept;
  logic          w_again;

  lcd_sync2 #(.WIDTH(4)) u_sync (
    .clk  (clk),
    .nrst (nrst),
    .d    (db_in),
    .q    (w_db)
  );

  assign w_byte   = {r_hi, r_lo};
  assign w_accept = (r_state == ST_IDLE) && rd_req;
  // Another poll pass only while BF is still set and the read budget remains
  assign w_again  = r_poll_en && w_byte[C_BF_BIT] &&
                    (r_poll_cnt < PW'(MAX_POLLS - 1));

  // Select the dwell time of the current state
  always_comb begin
    w_lim = CW'(1);
    case (r_state)
      ST_SETUP:         w_lim = CW'(T_AS);
      ST_EH1, ST_EH2:   w_lim = CW'(T_PW);
      ST_EL1, ST_EL2:   w_lim = CW'(T_LOW);
      default:          w_lim = CW'(1);
    endcase
  end

  assign w_last = (r_cnt == (w_lim - CW'(1)));

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  // Next-state logic: each timed state advances on its final count
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE:  if (rd_req) w_state_nx = ST_SETUP;
      ST_SETUP: if (w_last) w_state_nx = ST_EH1;
      ST_EH1:   if (w_last) w_state_nx = ST_EL1;
      ST_EL1:   if (w_last) w_state_nx = ST_EH2;
      ST_EH2:   if (w_last) w_state_nx = ST_EL2;
      ST_EL2:   if (w_last) w_state_nx = w_again ? ST_EH1 : ST_IDLE;
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // Bus pin and handshake decode; RS/RW only move on IDLE transitions
  always_comb begin
    lcd_e     = (r_state == ST_EH1) || (r_state == ST_EH2);
    rd_active = (r_state != ST_IDLE);
    rd_ready  = (r_state == ST_IDLE);
    lcd_rw    = rd_active;
    lcd_rs    = rd_active && r_rs;
  end

  // Dwell counter restarts on every state entry and idles at zero
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                                            r_cnt <= '0;
    else if (r_state == ST_IDLE || w_state_nx != r_state) r_cnt <= '0;
    else                                                  r_cnt <= r_cnt + CW'(1);
  end

  // Request capture, nibble sampling, poll bookkeeping and result delivery
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rs       <= 1'b0;
      r_poll_en  <= 1'b0;
      r_poll_cnt <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_data     <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_accept) begin
        r_rs       <= rd_rs;
        r_poll_en  <= rd_poll & ~rd_rs;
        r_poll_cnt <= '0;
      end
      if (r_state == ST_EH1 && w_last) r_hi <= w_db;
      if (r_state == ST_EH2 && w_last) r_lo <= w_db;
      if (r_state == ST_EL2 && w_last) begin
        if (w_again) begin
          r_poll_cnt <= r_poll_cnt + PW'(1);
        end else begin
          r_data    <= w_byte;
          r_valid   <= 1'b1;
          r_timeout <= r_poll_en & w_byte[C_BF_BIT];
        end
      end
    end
  end

  assign rd_data    = r_data;
  assign rd_valid   = r_valid;
  assign rd_timeout = r_timeout;

endmodule
`default_nettype wire
